// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: opcode/funct constants, ALU op and MUL FSM encodings for the execute stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ex_stage_pkg;

  // Major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // funct3 for OP / OP-IMM
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct3 for BRANCH
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct7 selecting the M extension (only MUL is implemented)
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [1:0] {
    MUL_IDLE, MUL_BUSY, MUL_DONE
  } mul_state_e;

  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic alu_op_e alu_op_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// ex_mul_iter: shift-add multiplier, one multiplier bit per cycle, low XLEN bits kept.
// Latency: start -> MUL_CYCLES BUSY cycles -> one DONE cycle with product valid.
// Backpressure: none; start is only honoured in IDLE, caller must hold off otherwise.
module ex_mul_iter #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);
  import ex_stage_pkg::*;

  localparam int             CW   = $clog2(MUL_CYCLES + 1);
  localparam logic [CW-1:0]  LAST = CW'(MUL_CYCLES - 1);

  mul_state_e      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;

  assign product = acc;

  // FSM plus datapath: latch operands on start, add shifted multiplicand per set bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= MUL_IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            state  <= MUL_BUSY;
            busy   <= 1'b1;
            cnt    <= '0;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
          end
        end
        MUL_BUSY: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= MUL_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        MUL_DONE: begin
          state <= MUL_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= MUL_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage; ALU, branch/jump resolution, iterative MUL, EX/MEM register.
// Latency: 1 cycle into EX/MEM for non-MUL; MUL_CYCLES+2 cycles for MUL.
// Backpressure: stall_o_if holds upstream during MUL while EX/MEM loads bubbles.
module ex_stage #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i_ex,
  input  logic [XLEN-1:0] pc_i_ex,
  input  logic [XLEN-1:0] pc_next_i_ex,
  input  logic [XLEN-1:0] r1_data_i_ex,
  input  logic [XLEN-1:0] r2_data_i_ex,
  input  logic [31:0]     instr_i_ex,
  input  logic [XLEN-1:0] imm_i_ex,
  input  logic [4:0]      writebackaddr_i_ex,
  output logic            stall_o_if,
  output logic            redirect_o_if,
  output logic [XLEN-1:0] redirect_pc_o_if,
  output logic            valid_o_mem,
  output logic [XLEN-1:0] alu_result_o_mem,
  output logic [XLEN-1:0] r2_data_o_mem,
  output logic [31:0]     instr_o_mem,
  output logic [XLEN-1:0] pc_next_o_mem,
  output logic [4:0]      writebackaddr_o_mem
);
  import ex_stage_pkg::*;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_op, is_mext, is_mul;

  assign opcode  = instr_i_ex[6:0];
  assign funct3  = instr_i_ex[14:12];
  assign funct7  = instr_i_ex[31:25];
  assign is_op   = (opcode == OPC_OP);
  assign is_mext = is_op && (funct7 == F7_MEXT);
  assign is_mul  = is_mext && (funct3 == F3_ADD);

  alu_op_e         alu_op;
  logic [XLEN-1:0] op_b, alu_out;

  // ALU: OP uses rs2, OP-IMM uses imm; SRAI is flagged by instr[30] only when funct3=101
  always_comb begin
    alu_op  = alu_op_decode(funct3, is_op ? funct7[5] : ((funct3 == F3_SR) && funct7[5]));
    op_b    = is_op ? r2_data_i_ex : imm_i_ex;
    alu_out = '0;
    case (alu_op)
      ALU_ADD:  alu_out = r1_data_i_ex + op_b;
      ALU_SUB:  alu_out = r1_data_i_ex - op_b;
      ALU_SLL:  alu_out = r1_data_i_ex << op_b[4:0];
      ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, ($signed(r1_data_i_ex) < $signed(op_b))};
      ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, (r1_data_i_ex < op_b)};
      ALU_XOR:  alu_out = r1_data_i_ex ^ op_b;
      ALU_SRL:  alu_out = r1_data_i_ex >> op_b[4:0];
      ALU_SRA:  alu_out = XLEN'($signed(r1_data_i_ex) >>> op_b[4:0]);
      ALU_OR:   alu_out = r1_data_i_ex | op_b;
      ALU_AND:  alu_out = r1_data_i_ex & op_b;
      default:  alu_out = '0;
    endcase
  end

  logic taken;

  // Branch condition on rs1/rs2
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (r1_data_i_ex == r2_data_i_ex);
      F3_BNE:  taken = (r1_data_i_ex != r2_data_i_ex);
      F3_BLT:  taken = ($signed(r1_data_i_ex) < $signed(r2_data_i_ex));
      F3_BGE:  taken = ($signed(r1_data_i_ex) >= $signed(r2_data_i_ex));
      F3_BLTU: taken = (r1_data_i_ex < r2_data_i_ex);
      F3_BGEU: taken = (r1_data_i_ex >= r2_data_i_ex);
      default: taken = 1'b0;
    endcase
  end

  logic [XLEN-1:0] pc_imm, r1_imm, result, target;
  logic            redir;

  assign pc_imm = pc_i_ex + imm_i_ex;
  assign r1_imm = r1_data_i_ex + imm_i_ex;

  // Per-opcode result and control-transfer target; M-ext and unknown opcodes give 0
  always_comb begin
    result = '0;
    redir  = 1'b0;
    target = '0;
    case (opcode)
      OPC_OP:               result = is_mext ? '0 : alu_out;
      OPC_OP_IMM:           result = alu_out;
      OPC_LUI:              result = imm_i_ex;
      OPC_AUIPC:            result = pc_imm;
      OPC_LOAD, OPC_STORE:  result = r1_imm;
      OPC_JAL: begin
        result = pc_next_i_ex;
        redir  = 1'b1;
        target = pc_imm;
      end
      OPC_JALR: begin
        result = pc_next_i_ex;
        redir  = 1'b1;
        target = {r1_imm[XLEN-1:1], 1'b0};
      end
      OPC_BRANCH: begin
        redir  = taken;
        target = pc_imm;
      end
      default: result = '0;
    endcase
  end

  // Gated by rst so nothing upstream-facing is asserted while the stage is held in reset
  assign redirect_o_if    = rst && valid_i_ex && redir;
  assign redirect_pc_o_if = redirect_o_if ? target : '0;

  logic            mul_busy, mul_done, mul_start;
  logic [XLEN-1:0] mul_product;

  assign mul_start  = rst && valid_i_ex && is_mul && !mul_busy && !mul_done;
  assign stall_o_if = mul_start || mul_busy;

  ex_mul_iter #(
    .XLEN       (XLEN),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (r1_data_i_ex),
    .b       (r2_data_i_ex),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  logic [31:0]     m_instr;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_pcn, m_r2;

  // Capture MUL metadata at start so the DONE write does not rely on upstream inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_instr <= '0;
      m_rd    <= '0;
      m_pcn   <= '0;
      m_r2    <= '0;
    end else if (mul_start) begin
      m_instr <= instr_i_ex;
      m_rd    <= writebackaddr_i_ex;
      m_pcn   <= pc_next_i_ex;
      m_r2    <= r2_data_i_ex;
    end
  end

  logic            n_valid;
  logic [XLEN-1:0] n_res, n_r2, n_pcn;
  logic [31:0]     n_instr;
  logic [4:0]      n_rd;

  // EX/MEM next value: bubble on stall or invalid input, product in DONE, else the bundle
  always_comb begin
    n_valid = 1'b0;
    n_res   = '0;
    n_r2    = '0;
    n_pcn   = '0;
    n_instr = '0;
    n_rd    = '0;
    if (!stall_o_if) begin
      if (mul_done) begin
        n_valid = 1'b1;
        n_res   = mul_product;
        n_r2    = m_r2;
        n_pcn   = m_pcn;
        n_instr = m_instr;
        n_rd    = m_rd;
      end else if (valid_i_ex) begin
        n_valid = 1'b1;
        n_res   = result;
        n_r2    = r2_data_i_ex;
        n_pcn   = pc_next_i_ex;
        n_instr = instr_i_ex;
        n_rd    = writebackaddr_i_ex;
      end
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o_mem         <= 1'b0;
      alu_result_o_mem    <= '0;
      r2_data_o_mem       <= '0;
      instr_o_mem         <= '0;
      pc_next_o_mem       <= '0;
      writebackaddr_o_mem <= '0;
    end else begin
      valid_o_mem         <= n_valid;
      alu_result_o_mem    <= n_res;
      r2_data_o_mem       <= n_r2;
      instr_o_mem         <= n_instr;
      pc_next_o_mem       <= n_pcn;
      writebackaddr_o_mem <= n_rd;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: self-checking bench for ex_stage against a behavioural RV32I execute model.
// Latency: checks 1-cycle non-MUL, MUL_CYCLES+2 MUL, same-cycle redirect.
// Backpressure: checks stall length and bubbles during MUL.
module tb_ex_stage;
  localparam int XLEN       = 32;
  localparam int MUL_CYCLES = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i_ex = 1'b0;
  logic [31:0] pc_i_ex = '0, pc_next_i_ex = '0, r1_data_i_ex = '0, r2_data_i_ex = '0;
  logic [31:0] instr_i_ex = '0, imm_i_ex = '0;
  logic [4:0]  writebackaddr_i_ex = '0;
  logic        stall_o_if, redirect_o_if, valid_o_mem;
  logic [31:0] redirect_pc_o_if, alu_result_o_mem, r2_data_o_mem, instr_o_mem, pc_next_o_mem;
  logic [4:0]  writebackaddr_o_mem;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst(rst), .valid_i_ex(valid_i_ex), .pc_i_ex(pc_i_ex),
    .pc_next_i_ex(pc_next_i_ex), .r1_data_i_ex(r1_data_i_ex), .r2_data_i_ex(r2_data_i_ex),
    .instr_i_ex(instr_i_ex), .imm_i_ex(imm_i_ex), .writebackaddr_i_ex(writebackaddr_i_ex),
    .stall_o_if(stall_o_if), .redirect_o_if(redirect_o_if), .redirect_pc_o_if(redirect_pc_o_if),
    .valid_o_mem(valid_o_mem), .alu_result_o_mem(alu_result_o_mem), .r2_data_o_mem(r2_data_o_mem),
    .instr_o_mem(instr_o_mem), .pc_next_o_mem(pc_next_o_mem), .writebackaddr_o_mem(writebackaddr_o_mem)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] arith(input logic [2:0] f3, input logic alt, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] s;
    s = b[4:0];
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << s;
      3'd2:    return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? ((a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0)) : (a >> s);
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic lt_s;
    lt_s = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return lt_s;
      3'd5:    return !lt_s;
      3'd6:    return a < b;
      3'd7:    return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_result(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm);
    case (ins[6:0])
      OPC_OP:              return (ins[31:25] == 7'h01) ? 32'd0 : arith(ins[14:12], ins[30], r1, r2);
      OPC_IMM:             return arith(ins[14:12], (ins[14:12] == 3'd5) && ins[30], r1, imm);
      OPC_LUI:             return imm;
      OPC_AUIPC:           return pc + imm;
      OPC_LOAD, OPC_STORE: return r1 + imm;
      OPC_JAL, OPC_JALR:   return pc + 32'd4;
      default:             return 32'd0;
    endcase
  endfunction

  // {redirect, target}
  function automatic logic [32:0] model_redirect(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm);
    case (ins[6:0])
      OPC_JAL:    return {1'b1, pc + imm};
      OPC_JALR:   return {1'b1, (r1 + imm) & 32'hFFFF_FFFE};
      OPC_BRANCH: return br_taken(ins[14:12], r1, r2) ? {1'b1, pc + imm} : 33'd0;
      default:    return 33'd0;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] imm, input logic [4:0] rd);
    valid_i_ex = v; instr_i_ex = ins; pc_i_ex = pc; pc_next_i_ex = pc + 32'd4;
    r1_data_i_ex = r1; r2_data_i_ex = r2; imm_i_ex = imm; writebackaddr_i_ex = rd;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(posedge clk); #1;
    n_checks++; if ({valid_o_mem, alu_result_o_mem, r2_data_o_mem, instr_o_mem, pc_next_o_mem, writebackaddr_o_mem} !== '0) begin
      n_fail++; $display("FAIL reset_exmem: got valid=%0b res=%h rd=%0d, need all 0", valid_o_mem, alu_result_o_mem, writebackaddr_o_mem); end
    n_checks++; if ({stall_o_if, redirect_o_if, redirect_pc_o_if} !== '0) begin
      n_fail++; $display("FAIL reset_ctrl: got stall=%0b redir=%0b pc=%h, need 0", stall_o_if, redirect_o_if, redirect_pc_o_if); end
    rst = 1'b1;
    drive(1'b1, {12'd9, 5'd0, 3'd0, 5'd3, OPC_IMM}, 32'h40, 32'd1, 32'd2, 32'd9, 5'd3);
    @(posedge clk); #1;
    n_checks++; if (alu_result_o_mem !== 32'd10 || valid_o_mem !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_addi: got valid=%0b res=%h, need 1/0000000a", valid_o_mem, alu_result_o_mem); end
    #4; rst = 1'b0; #1;
    n_checks++; if ({valid_o_mem, alu_result_o_mem, r2_data_o_mem, instr_o_mem, pc_next_o_mem, writebackaddr_o_mem, stall_o_if, redirect_o_if} !== '0) begin
      n_fail++; $display("FAIL async_reset: got valid=%0b res=%h instr=%h, need all 0", valid_o_mem, alu_result_o_mem, instr_o_mem); end
    @(posedge clk); #1; rst = 1'b1;
    drive(1'b1, {12'd7, 5'd0, 3'd0, 5'd5, OPC_IMM}, 32'h80, 32'd0, 32'd0, 32'd7, 5'd5);
    @(posedge clk); #1;
    n_checks++; if ({valid_o_mem, alu_result_o_mem, writebackaddr_o_mem} !== {1'b1, 32'd7, 5'd5}) begin
      n_fail++; $display("FAIL addi_after_reset: got valid=%0b res=%h rd=%0d, need 1/00000007/5", valid_o_mem, alu_result_o_mem, writebackaddr_o_mem); end
  endtask

  task automatic test_sub_sra();
    logic [31:0] exp [4];
    logic [2:0]  f3s [4];
    logic [6:0]  f7s [4];
    exp[0] = 32'h7FFF_FFFC; f3s[0] = 3'd0; f7s[0] = 7'h20;
    exp[1] = 32'hF800_0000; f3s[1] = 3'd5; f7s[1] = 7'h20;
    exp[2] = 32'd0;         f3s[2] = 3'd3; f7s[2] = 7'h00;
    exp[3] = 32'd1;         f3s[3] = 3'd2; f7s[3] = 7'h00;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, {f7s[i], 10'd0, f3s[i], 5'd6, OPC_OP}, 32'h200, 32'h8000_0000, 32'd4, 32'd0, 5'd6);
      @(posedge clk); #1;
      n_checks++; if (alu_result_o_mem !== exp[i] || valid_o_mem !== 1'b1) begin
        n_fail++; $display("FAIL sub_sra_slt[%0d]: got valid=%0b res=%h, need 1/%h", i, valid_o_mem, alu_result_o_mem, exp[i]); end
    end
  endtask

  task automatic test_branch();
    drive(1'b1, {7'd0, 10'd0, 3'd0, 5'd0, OPC_BRANCH}, 32'h100, 32'd3, 32'd3, 32'h20, 5'd0);
    #4;
    n_checks++; if (redirect_o_if !== 1'b1 || redirect_pc_o_if !== 32'h120) begin
      n_fail++; $display("FAIL beq_taken: got redir=%0b pc=%h, need 1/00000120", redirect_o_if, redirect_pc_o_if); end
    @(posedge clk); #1;
    n_checks++; if (valid_o_mem !== 1'b1 || instr_o_mem !== instr_i_ex) begin
      n_fail++; $display("FAIL beq_retire: got valid=%0b instr=%h", valid_o_mem, instr_o_mem); end
    drive(1'b1, {7'd0, 10'd0, 3'd0, 5'd0, OPC_BRANCH}, 32'h100, 32'd3, 32'd4, 32'h20, 5'd0);
    #4;
    n_checks++; if (redirect_o_if !== 1'b0 || redirect_pc_o_if !== 32'd0) begin
      n_fail++; $display("FAIL beq_not_taken: got redir=%0b pc=%h, need 0/0", redirect_o_if, redirect_pc_o_if); end
    @(posedge clk); #1;
  endtask

  task automatic test_jalr();
    drive(1'b1, {12'd0, 5'd1, 3'd0, 5'd1, OPC_JALR}, 32'h400, 32'h203, 32'd0, 32'd0, 5'd1);
    #4;
    n_checks++; if (redirect_o_if !== 1'b1 || redirect_pc_o_if !== 32'h202) begin
      n_fail++; $display("FAIL jalr_target: got redir=%0b pc=%h, need 1/00000202", redirect_o_if, redirect_pc_o_if); end
    @(posedge clk); #1;
    n_checks++; if (alu_result_o_mem !== 32'h404 || valid_o_mem !== 1'b1) begin
      n_fail++; $display("FAIL jalr_link: got valid=%0b res=%h, need 1/00000404", valid_o_mem, alu_result_o_mem); end
  endtask

  task automatic test_random_stream(input int n);
    logic [31:0] ins, pc, r1, r2, imm, exp_res, exp_tgt;
    logic [11:0] i12;
    logic [6:0]  f7, opc;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        v, exp_red;
    int          kind, pick;
    for (int i = 0; i < n; i++) begin
      pc = $urandom & 32'hFFFF_FFFC; r1 = $urandom; r2 = $urandom; rd = 5'($urandom);
      v = ($urandom_range(0, 7) != 0); f3 = 3'($urandom);
      i12 = 12'($urandom); imm = {{20{i12[11]}}, i12}; f7 = i12[11:5];
      kind = $urandom_range(0, 9);
      case (kind)
        0: begin opc = OPC_OP; f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00; end
        1, 2: begin
          opc = OPC_IMM;
          if (f3 == 3'd1 || f3 == 3'd5) begin
            i12 = {1'b0, (f3 == 3'd5) && ($urandom_range(0, 1) == 1), 5'd0, 5'($urandom)};
            imm = {20'd0, i12};
          end
          f7 = i12[11:5];
        end
        3: begin opc = OPC_LUI;   imm = $urandom & 32'hFFFF_F000; end
        4: begin opc = OPC_AUIPC; imm = $urandom & 32'hFFFF_F000; end
        5: opc = ($urandom_range(0, 1) == 1) ? OPC_LOAD : OPC_STORE;
        6: begin opc = OPC_JAL; imm = $urandom & 32'h001F_FFFE; end
        7: opc = OPC_JALR;
        8: begin
          opc = OPC_BRANCH; pick = $urandom_range(0, 5);
          f3 = (pick < 2) ? 3'(pick) : 3'(pick + 2);
          if ($urandom_range(0, 3) == 0) r2 = r1;
        end
        default: begin
          if ($urandom_range(0, 1) == 1) begin opc = OPC_OP; f7 = 7'h01; f3 = 3'($urandom_range(1, 7)); end
          else opc = ($urandom_range(0, 1) == 1) ? 7'b0001111 : 7'b1110011;
        end
      endcase
      ins = {f7, 10'd0, f3, rd, opc};
      exp_res = v ? model_result(ins, pc, r1, r2, imm) : 32'd0;
      {exp_red, exp_tgt} = v ? model_redirect(ins, pc, r1, r2, imm) : 33'd0;
      drive(v, ins, pc, r1, r2, imm, rd);
      #4;
      n_checks++; if (redirect_o_if !== exp_red) begin
        n_fail++; $display("FAIL rand_redirect[%0d]: instr=%h got %0b need %0b", i, ins, redirect_o_if, exp_red); end
      n_checks++; if (redirect_pc_o_if !== exp_tgt) begin
        n_fail++; $display("FAIL rand_target[%0d]: instr=%h got %h need %h", i, ins, redirect_pc_o_if, exp_tgt); end
      n_checks++; if (stall_o_if !== 1'b0) begin
        n_fail++; $display("FAIL rand_stall[%0d]: instr=%h got %0b need 0", i, ins, stall_o_if); end
      @(posedge clk); #1;
      n_checks++; if (valid_o_mem !== v) begin
        n_fail++; $display("FAIL rand_valid[%0d]: got %0b need %0b", i, valid_o_mem, v); end
      n_checks++; if (alu_result_o_mem !== exp_res) begin
        n_fail++; $display("FAIL rand_result[%0d]: instr=%h r1=%h r2=%h imm=%h got %h need %h", i, ins, r1, r2, imm, alu_result_o_mem, exp_res); end
      n_checks++; if ({r2_data_o_mem, instr_o_mem, pc_next_o_mem, writebackaddr_o_mem} !== (v ? {r2, ins, pc + 32'd4, rd} : 101'd0)) begin
        n_fail++; $display("FAIL rand_fields[%0d]: got r2=%h instr=%h pcn=%h rd=%0d", i, r2_data_o_mem, instr_o_mem, pc_next_o_mem, writebackaddr_o_mem); end
    end
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
  endtask

  // Presents a MUL and holds it while stalled; returns latency, stall cycles and bad bubbles
  task automatic do_mul(input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] rd, input logic [31:0] pc,
                        output int lat, output int stall_cnt, output int bubble_bad);
    drive(1'b1, {7'h01, 10'd0, 3'd0, rd, OPC_OP}, pc, r1, r2, 32'd0, rd);
    lat = 0; stall_cnt = 0; bubble_bad = 0;
    #4; if (stall_o_if) stall_cnt++;
    for (int k = 1; k <= MUL_CYCLES + 20 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (valid_o_mem) lat = k;
      else begin
        if ({alu_result_o_mem, r2_data_o_mem, instr_o_mem, pc_next_o_mem, writebackaddr_o_mem} != '0) bubble_bad++;
        #4; if (stall_o_if) stall_cnt++;
      end
    end
  endtask

  task automatic test_mul();
    logic [31:0] a [2];
    logic [31:0] b [2];
    int lat, sc, bb;
    a[0] = 32'hFFFF_FFFF; b[0] = 32'd3;
    a[1] = 32'd7;         b[1] = 32'd6;
    for (int i = 0; i < 2; i++) begin
      do_mul(a[i], b[i], 5'(7 + i), 32'h1000 + 32'(i * 4), lat, sc, bb);
      n_checks++; if (lat !== MUL_CYCLES + 2) begin
        n_fail++; $display("FAIL mul_latency[%0d]: got %0d need %0d (0 = never valid)", i, lat, MUL_CYCLES + 2); end
      n_checks++; if (sc !== MUL_CYCLES + 1) begin
        n_fail++; $display("FAIL mul_stall_cycles[%0d]: got %0d need %0d", i, sc, MUL_CYCLES + 1); end
      n_checks++; if (bb !== 0) begin
        n_fail++; $display("FAIL mul_bubbles[%0d]: got %0d non-zero bubbles need 0", i, bb); end
      n_checks++; if (alu_result_o_mem !== 32'(a[i] * b[i])) begin
        n_fail++; $display("FAIL mul_result[%0d]: got %h need %h", i, alu_result_o_mem, 32'(a[i] * b[i])); end
      n_checks++; if ({writebackaddr_o_mem, pc_next_o_mem} !== {5'(7 + i), 32'h1004 + 32'(i * 4)}) begin
        n_fail++; $display("FAIL mul_meta[%0d]: got rd=%0d pcn=%h", i, writebackaddr_o_mem, pc_next_o_mem); end
    end
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    @(posedge clk); #1;
    n_checks++; if (valid_o_mem !== 1'b0 || stall_o_if !== 1'b0) begin
      n_fail++; $display("FAIL mul_idle_after: got valid=%0b stall=%0b need 0/0", valid_o_mem, stall_o_if); end
  endtask

  task automatic test_reset_mid_mul();
    drive(1'b1, {7'h01, 10'd0, 3'd0, 5'd2, OPC_OP}, 32'h2000, 32'h1234, 32'h55, 32'd0, 5'd2);
    repeat (10) @(posedge clk);
    #4;
    n_checks++; if (stall_o_if !== 1'b1) begin
      n_fail++; $display("FAIL mid_mul_stall: got %0b need 1", stall_o_if); end
    rst = 1'b0; #1;
    n_checks++; if ({stall_o_if, valid_o_mem, alu_result_o_mem, instr_o_mem} !== '0) begin
      n_fail++; $display("FAIL mid_mul_reset: got stall=%0b valid=%0b res=%h need 0", stall_o_if, valid_o_mem, alu_result_o_mem); end
    drive(1'b1, {7'h00, 10'd0, 3'd0, 5'd4, OPC_OP}, 32'h3000, 32'd5, 32'd9, 32'd0, 5'd4);
    @(posedge clk); #1; rst = 1'b1;
    #4;
    n_checks++; if (stall_o_if !== 1'b0) begin
      n_fail++; $display("FAIL add_after_reset_stall: got %0b need 0", stall_o_if); end
    @(posedge clk); #1;
    n_checks++; if ({valid_o_mem, alu_result_o_mem, writebackaddr_o_mem} !== {1'b1, 32'd14, 5'd4}) begin
      n_fail++; $display("FAIL add_after_reset: got valid=%0b res=%h rd=%0d need 1/0000000e/4", valid_o_mem, alu_result_o_mem, writebackaddr_o_mem); end
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    @(posedge clk); #1;
    n_checks++; if (valid_o_mem !== 1'b0) begin
      n_fail++; $display("FAIL no_stale_mul: got valid=%0b res=%h need 0", valid_o_mem, alu_result_o_mem); end
  endtask

  initial begin
    test_reset();
    test_sub_sra();
    test_branch();
    test_jalr();
    test_random_stream(300);
    test_mul();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RISC-V pipeline and the consuming end of the IF/ID front end's EX-bound bundle. It accepts `pc`, `pc_next`, `r1_data`, `r2_data`, `instr`, `imm` and `writebackaddr` from the ID/EX register, and computes the ALU, branch and jump results. It drives redirect and stall back to IF/ID and registers the outcome into the EX/MEM bundle. RV32I integer ops plus an iterative multi-cycle `MUL`.

## Interface

Parameters:
- `XLEN`, 32: datapath width.
- `MUL_CYCLES`, 32: `MUL` iteration count, one multiplier bit per cycle.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `valid_i_ex`, in, 1: bundle valid.
- `pc_i_ex`, in, XLEN: instruction PC.
- `pc_next_i_ex`, in, XLEN: PC + 4.
- `r1_data_i_ex`, in, XLEN: rs1 operand.
- `r2_data_i_ex`, in, XLEN: rs2 operand.
- `instr_i_ex`, in, 32: raw instruction.
- `imm_i_ex`, in, XLEN: sign-extended immediate.
- `writebackaddr_i_ex`, in, 5: rd.
- `stall_o_if`, out, 1: hold IF/ID/ID-EX registers.
- `redirect_o_if`, out, 1: redirect fetch and flush IF/ID.
- `redirect_pc_o_if`, out, XLEN: redirect target.
- `valid_o_mem`, out, 1: EX/MEM valid.
- `alu_result_o_mem`, out, XLEN: result or effective address.
- `r2_data_o_mem`, out, XLEN: store data.
- `instr_o_mem`, out, 32: passed instruction.
- `pc_next_o_mem`, out, XLEN: link value.
- `writebackaddr_o_mem`, out, 5: rd.

## Operation

- Decode from `instr_i_ex` opcode, funct3 and funct7[5]/funct7[0].
- **OP / OP-IMM:** ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. Shift amount is `b[4:0]`. Arithmetic is modulo 2^32.
- **LUI:** result = `imm`.
- **AUIPC:** result = `pc` + `imm`.
- **LOAD / STORE:** result = `r1` + `imm`.
- **JAL:** result = `pc_next`; target = `pc` + `imm`.
- **JALR:** result = `pc_next`; target = (`r1` + `imm`) with bit 0 cleared.
- **BRANCH:** BEQ, BNE, BLT, BGE, BLTU, BGEU. Taken target = `pc` + `imm`.
- **Redirect:** `redirect_o_if` is combinational and is high iff `valid_i_ex` and the instruction is JAL, JALR, or a taken branch. `redirect_pc_o_if` = target; it is 0 when not redirecting.
- **MUL** (opcode OP, funct7 = 0000001, funct3 = 000): low 32 bits of `r1`×`r2`, shift-add.
- **Other** funct7 = 0000001 encodings and unknown opcodes: result = 0, valid passed through, no redirect.
- **FSM** states:
  - IDLE → BUSY when `valid_i_ex` & `MUL`; the counter clears and operands are latched.
  - BUSY: one bit per cycle. Moves to DONE when the counter = `MUL_CYCLES` − 1.
  - DONE → IDLE unconditionally.
- `stall_o_if` = (IDLE & `valid_i_ex` & `MUL`) | BUSY. It is low in DONE.
- While `stall_o_if` = 1, the EX/MEM register loads a bubble: `valid_o_mem` = 0, all other outputs 0.
- In DONE, EX/MEM captures the product together with the latched instruction, rd and `pc_next`.
- `writebackaddr` = 0 passes through unchanged. Write suppression for x0 is downstream's responsibility.

## Timing

- **Reset:** all outputs 0, FSM IDLE, counter 0. The reset is asynchronous and takes effect mid-`MUL`; the partial product is discarded.
- **Non-MUL:** EX/MEM outputs update on the first rising edge after the bundle is presented. Latency is 1 cycle; throughput is 1 per cycle.
- **Redirect:** same cycle as the branch is in EX. Upstream flushes younger instructions on that edge. The branch itself retires normally into EX/MEM.
- **MUL:**
  - Stall asserts combinationally in the presentation cycle and stays high for `MUL_CYCLES` + 1 cycles.
  - The DONE cycle follows, and the result appears on EX/MEM at the edge ending DONE.
  - Total latency is `MUL_CYCLES` + 2 cycles.
  - Upstream holds its inputs stable while stalled.
- Back-to-back `MUL`s: the second is presented in the cycle after DONE and re-enters BUSY with no extra gap.
- `valid_i_ex` = 0 gives a bubble out, with no stall and no redirect.

## Structure

- Opcode, funct3 and funct7 constants and ALU-op encodings go in `defines.v`. The FSM state encodings go there as well.
- Sub-module `ex_mul_iter` holds the FSM, counter, multiplicand/multiplier shift registers, accumulator, `busy` and `done`.
- The ALU, branch compare and the EX/MEM register stay in `ex_stage`.

## Test plan

- **Reset:** hold `rst` = 0 mid-run → all outputs 0. Release, then present `ADDI x5,x0,7` → next edge gives `valid_o_mem` = 1, `alu_result` = 7, `writebackaddr` = 5.
- **SUB/SRA:** r1 = 0x80000000, r2 = 4 → SUB = 0x7FFFFFFC; SRA = 0xF8000000; SLTU(r1, r2) = 0, SLT = 1.
- **Branch:** BEQ with r1 = r2 = 3, pc = 0x100, imm = 0x20 → `redirect` = 1 and target = 0x120 in the same cycle. With r2 = 4 → `redirect` = 0.
- **JALR:** r1 = 0x203, imm = 0 → target = 0x202; result = `pc_next`.
- **MUL:** 0xFFFFFFFF × 3 → result 0xFFFFFFFD. Stall is high for exactly 33 cycles with bubbles out, and valid appears 34 cycles after presentation. A back-to-back second `MUL` 7×6 gives 42.
- **Reset mid-MUL:** `rst` = 0 at BUSY cycle 10 → stall drops and outputs clear. After release, a new ADD completes in 1 cycle.
